// File: rtl/move_scheduler_pkg.sv
// Shared sizing defaults and state encoding for the move scheduler and its segment FIFO.
package move_scheduler_pkg;

    localparam int MOVE_BUFFER_BITS = 2;
    localparam int DUR_W            = 64;
    localparam int INC_W            = 64;
    localparam int DIV_W            = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/move_fifo.sv
// Circular segment buffer: 2^DEPTH_BITS entries of flat segment words with push/pop/flush.
module move_fifo #(
    parameter int DEPTH_BITS = 2,
    parameter int WIDTH      = 8
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_BITS:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == (DEPTH_BITS+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // Storage is data only and carries no reset.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Buffered move sequencer: queues DDA segments, releases them one at a time, divides CLK into DDA ticks.
// Optional abort/empty port `flush` is compiled in when MOVE_FLUSH_EN is defined.
module move_scheduler #(
    parameter int DEPTH_BITS = move_scheduler_pkg::MOVE_BUFFER_BITS,
    parameter int DUR_W      = move_scheduler_pkg::DUR_W,
    parameter int INC_W      = move_scheduler_pkg::INC_W,
    parameter int DIV_W      = move_scheduler_pkg::DIV_W
) (
    input  logic                    CLK,
    input  logic                    resetn,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic                    wr_dir,
    input  logic [DUR_W-1:0]        wr_duration,
    input  logic signed [INC_W-1:0] wr_inc,
    input  logic signed [INC_W-1:0] wr_incinc,
    input  logic [DIV_W-1:0]        clock_divisor,
    output logic                    dda_start,
    output logic                    dda_tick,
    output logic                    dda_dir,
    output logic signed [INC_W-1:0] dda_inc,
    output logic signed [INC_W-1:0] dda_incinc,
    output logic                    busy,
    output logic [DEPTH_BITS:0]     count,
    output logic                    underrun,
    input  logic                    underrun_clr
`ifdef MOVE_FLUSH_EN
    ,
    input  logic                    flush
`endif
);

    import move_scheduler_pkg::*;

    localparam int SEG_W = 1 + DUR_W + 2 * INC_W;

    state_t                  state;
    state_t                  state_nxt;
    logic [DIV_W-1:0]        divcnt;
    logic [DIV_W-1:0]        eff_div_m1;
    logic [DUR_W-1:0]        remaining;
    logic                    act_dir;
    logic signed [INC_W-1:0] act_inc;
    logic signed [INC_W-1:0] act_incinc;

    logic [SEG_W-1:0]        seg_in;
    logic [SEG_W-1:0]        seg_head;
    logic                    head_dir;
    logic [DUR_W-1:0]        head_dur;
    logic signed [INC_W-1:0] head_inc;
    logic signed [INC_W-1:0] head_incinc;

    logic                    push;
    logic                    pop;
    logic                    last_tick;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    flush_req;

`ifdef MOVE_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign seg_in      = {wr_dir, wr_duration, wr_inc, wr_incinc};
    assign head_dir    = seg_head[SEG_W-1];
    assign head_dur    = seg_head[SEG_W-2 -: DUR_W];
    assign head_inc    = seg_head[2*INC_W-1 -: INC_W];
    assign head_incinc = seg_head[INC_W-1:0];

    // Zero-length segments complete the handshake but never occupy a slot.
    assign wr_ready = !fifo_full;
    assign push     = wr_valid && wr_ready && (wr_duration != '0) && !flush_req;

    move_fifo #(
        .DEPTH_BITS (DEPTH_BITS),
        .WIDTH      (SEG_W)
    ) u_fifo (
        .CLK     (CLK),
        .resetn  (resetn),
        .push    (push),
        .pop     (pop),
        .flush   (flush_req),
        .wr_data (seg_in),
        .rd_data (seg_head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        dda_start  = 1'b0;
        dda_tick   = 1'b0;
        last_tick  = 1'b0;
        eff_div_m1 = (clock_divisor == '0) ? '0 : clock_divisor - 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                pop       = 1'b1;
                dda_start = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (divcnt == eff_div_m1) begin
                    dda_tick = 1'b1;
                    if (remaining == DUR_W'(1)) begin
                        last_tick = 1'b1;
                        state_nxt = fifo_empty ? IDLE : LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_req) begin
            state_nxt = IDLE;
            pop       = 1'b0;
            dda_start = 1'b0;
            dda_tick  = 1'b0;
            last_tick = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            divcnt     <= '0;
            remaining  <= '0;
            act_dir    <= 1'b0;
            act_inc    <= '0;
            act_incinc <= '0;
            underrun   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush_req) begin
                divcnt    <= '0;
                remaining <= '0;
            end else if (state == LOAD) begin
                divcnt     <= '0;
                remaining  <= head_dur;
                act_dir    <= head_dir;
                act_inc    <= head_inc;
                act_incinc <= head_incinc;
            end else if (state == RUN) begin
                // divcnt wraps at 2^DIV_W if the divisor drops below it mid-segment.
                if (dda_tick) begin
                    divcnt    <= '0;
                    remaining <= remaining - 1'b1;
                end else begin
                    divcnt <= divcnt + 1'b1;
                end
            end
            if (last_tick && fifo_empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    // During the start pulse the outputs already show the segment being loaded.
    assign busy       = (state == LOAD) || (state == RUN);
    assign dda_dir    = (state == LOAD) ? head_dir    : act_dir;
    assign dda_inc    = (state == LOAD) ? head_inc    : act_inc;
    assign dda_incinc = (state == LOAD) ? head_incinc : act_incinc;

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: queued segments are checked at each dda_start, ticks for spacing and count.
module tb_move_scheduler;

    localparam int DB    = 2;
    localparam int DUR_W = 64;
    localparam int INC_W = 64;
    localparam int DIV_W = 24;

    logic                    CLK = 1'b0;
    logic                    resetn = 1'b0;
    logic                    wr_valid = 1'b0;
    logic                    wr_ready;
    logic                    wr_dir = 1'b0;
    logic [DUR_W-1:0]        wr_duration = '0;
    logic signed [INC_W-1:0] wr_inc = '0;
    logic signed [INC_W-1:0] wr_incinc = '0;
    logic [DIV_W-1:0]        clock_divisor = '0;
    logic                    dda_start;
    logic                    dda_tick;
    logic                    dda_dir;
    logic signed [INC_W-1:0] dda_inc;
    logic signed [INC_W-1:0] dda_incinc;
    logic                    busy;
    logic [DB:0]             count;
    logic                    underrun;
    logic                    underrun_clr = 1'b0;
`ifdef MOVE_FLUSH_EN
    logic                    flush = 1'b0;
`endif

    move_scheduler #(
        .DEPTH_BITS (DB),
        .DUR_W      (DUR_W),
        .INC_W      (INC_W),
        .DIV_W      (DIV_W)
    ) dut (
        .CLK           (CLK),
        .resetn        (resetn),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_dir        (wr_dir),
        .wr_duration   (wr_duration),
        .wr_inc        (wr_inc),
        .wr_incinc     (wr_incinc),
        .clock_divisor (clock_divisor),
        .dda_start     (dda_start),
        .dda_tick      (dda_tick),
        .dda_dir       (dda_dir),
        .dda_inc       (dda_inc),
        .dda_incinc    (dda_incinc),
        .busy          (busy),
        .count         (count),
        .underrun      (underrun),
        .underrun_clr  (underrun_clr)
`ifdef MOVE_FLUSH_EN
        ,
        .flush         (flush)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        dir;
        logic [63:0] dur;
        logic [63:0] inc;
        logic [63:0] incinc;
    } seg_t;

    seg_t exp_q[$];
    seg_t cur;
    bit   cur_valid = 1'b0;
    bit   b2b = 1'b0;
    int   cur_ticks = 0;
    int   start_cyc = 0;
    int   last_tick_cyc = 0;
    int   exp_div = 1;
    int   n_starts = 0;
    int   n_ticks = 0;
    int   last_accept = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every start pulse and times every tick.
    always @(negedge CLK) begin
        if (!resetn) begin
            cur_valid = 1'b0;
        end else begin
            if (dda_start) begin
                if (cur_valid) begin
                    check("seg_ticks", cur_ticks, cur.dur);
                    if (b2b) check("b2b_start_gap", cyc - last_tick_cyc, 1);
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                    cur_valid = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                    check("dda_inc", dda_inc, cur.inc);
                    check("dda_incinc", dda_incinc, cur.incinc);
                    check("dda_dir", dda_dir, cur.dir);
                end
                cur_ticks = 0;
                start_cyc = cyc;
                n_starts++;
            end
            if (dda_tick) begin
                n_ticks++;
                if (!cur_valid) begin
                    check("orphan_tick", 1, 0);
                end else begin
                    check("tick_gap", cyc - ((cur_ticks == 0) ? start_cyc : last_tick_cyc), exp_div);
                    check("inc_hold", dda_inc, cur.inc);
                    cur_ticks++;
                end
                last_tick_cyc = cyc;
            end
        end
    end

    task automatic write_seg(input bit dir, input logic [63:0] dur, input logic [63:0] inc,
                             input logic [63:0] incinc);
        int n = 0;
        wr_valid    = 1'b1;
        wr_dir      = dir;
        wr_duration = dur;
        wr_inc      = inc;
        wr_incinc   = incinc;
        while (!wr_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!wr_ready) check("wr_ready_timeout", 0, 1);
        if (dur != 0) exp_q.push_back({dir, dur, inc, incinc});
        last_accept = cyc;
        @(posedge CLK);
        @(negedge CLK);
        wr_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((busy || count != 0) && n < budget);
        if (busy || count != 0) check("drain_timeout", 0, 1);
        if (cur_valid) check("seg_ticks_end", cur_ticks, cur.dur);
        cur_valid = 1'b0;
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int base_t;
        int base_s;
        int n;
        int k;

        // Reset state
        @(negedge CLK);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_underrun", underrun, 0);
        check("rst_start", dda_start, 0);
        check("rst_tick", dda_tick, 0);
        check("rst_inc", dda_inc, 0);
        check("rst_incinc", dda_incinc, 0);
        check("rst_dir", dda_dir, 0);
        resetn = 1'b1;
        @(negedge CLK);

        // Divisor 4, single segment of duration 3
        clock_divisor = 4;
        exp_div = 4;
        base_s = n_starts;
        base_t = n_ticks;
        write_seg(1'b1, 3, 64'h10, 2);
        n = 0;
        while (n_starts == base_s && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("start_latency", start_cyc - last_accept, 2);
        drain(100);
        check("t1_ticks", n_ticks - base_t, 3);
        check("t1_underrun", underrun, 1);
        check("t1_inc_idle_hold", dda_inc, 64'h10);
        check("t1_dir_idle_hold", dda_dir, 1);
        underrun_clr = 1'b1;
        @(negedge CLK);
        underrun_clr = 1'b0;
        check("underrun_clr", underrun, 0);

        // Back-to-back segments fill the buffer, divisor 2
        clock_divisor = 2;
        exp_div = 2;
        b2b = 1'b1;
        base_s = n_starts;
        base_t = n_ticks;
        for (int i = 0; i < 5; i++) write_seg(i[0], 2, 64'(100 + i), 64'(-i));
        check("full_count", count, 4);
        check("full_wr_ready", wr_ready, 0);
        write_seg(1'b0, 2, 64'h55, 64'h7);
        n = 0;
        while (!(count == 0 && busy && !dda_start) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("b2b_no_early_underrun", underrun, 0);
        drain(200);
        b2b = 1'b0;
        check("b2b_starts", n_starts - base_s, 6);
        check("b2b_ticks", n_ticks - base_t, 12);
        check("b2b_final_underrun", underrun, 1);

        // Zero-duration segment between two valid ones, divisor 1
        clock_divisor = 1;
        exp_div = 1;
        base_s = n_starts;
        write_seg(1'b0, 2, 64'hA, 0);
        write_seg(1'b1, 0, 64'hBAD, 64'hBAD);
        check("zero_dur_count", count, 1);
        write_seg(1'b1, 2, 64'hB, 1);
        drain(100);
        check("zero_dur_starts", n_starts - base_s, 2);

        // Divisor 0 behaves like divisor 1
        clock_divisor = 0;
        exp_div = 1;
        base_t = n_ticks;
        write_seg(1'b0, 4, -64'sd3, 64'h1);
        drain(100);
        check("div0_ticks", n_ticks - base_t, 4);

        // Reset on the 2nd tick of a 5-tick segment
        clock_divisor = 3;
        exp_div = 3;
        write_seg(1'b1, 5, 64'h77, 64'h3);
        k = 0;
        n = 0;
        while (k < 2 && n < 100) begin
            @(negedge CLK);
            if (dda_tick) k++;
            n++;
        end
        check("rst_mid_reached_tick2", k, 2);
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_tick", dda_tick, 0);
        check("rst_mid_count", count, 0);
        check("rst_mid_inc", dda_inc, 0);
        @(negedge CLK);
        base_t = n_ticks;
        base_s = n_starts;
        resetn = 1'b1;
        repeat (20) @(negedge CLK);
        check("rst_mid_no_ticks", n_ticks - base_t, 0);
        check("rst_mid_no_starts", n_starts - base_s, 0);
        check("rst_mid_underrun", underrun, 0);

`ifdef MOVE_FLUSH_EN
        // Flush during RUN with three queued
        clock_divisor = 3;
        exp_div = 3;
        for (int i = 0; i < 4; i++) write_seg(1'b0, 5, 64'(i), 0);
        check("flush_pre_count", count, 3);
        check("flush_pre_busy", busy, 1);
        base_t = n_ticks;
        base_s = n_starts;
        flush = 1'b1;
        #1;
        check("flush_no_tick", dda_tick, 0);
        @(negedge CLK);
        flush = 1'b0;
        exp_q.delete();
        cur_valid = 1'b0;
        check("flush_count", count, 0);
        check("flush_busy", busy, 0);
        check("flush_underrun", underrun, 0);
        repeat (15) @(negedge CLK);
        check("flush_no_more_ticks", n_ticks - base_t, 0);
        check("flush_no_more_starts", n_starts - base_s, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
